// File: rtl/mult_ctrl.sv
// Control FSM for the approximate 16x16 multiplier: normalizes both operands,
// multiplies the top bytes, then shifts the result back to full magnitude.
module mult_ctrl #(
    parameter int unsigned RES_SHIFT_BASE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       a_msb,
    input  logic       b_msb,
    input  logic       co_a,
    input  logic       co_b,
    input  logic [2:0] count_a,
    input  logic [2:0] count_b,
    output logic       ld_a,
    output logic       ld_b,
    output logic       cnt_clean_a,
    output logic       cnt_clean_b,
    output logic       shift_en_a,
    output logic       shift_en_b,
    output logic       cnt_en_a,
    output logic       cnt_en_b,
    output logic       ld_res,
    output logic       shift_en_res,
    output logic       busy,
    output logic       done
);

    localparam int unsigned RS_W = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        NORM  = 3'd2,
        MULT  = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [RS_W-1:0]   rs_cnt_q, rs_cnt_d;
    logic              stop_a, stop_b;

    // An operand stops once its MSB is set or its counter saturates.
    assign stop_a = a_msb | co_a;
    assign stop_b = b_msb | co_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rs_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rs_cnt_q <= rs_cnt_d;
        end
    end

    // Next state and strobe decode; strobes depend only on state and datapath status.
    always_comb begin
        state_d      = state_q;
        rs_cnt_d     = rs_cnt_q;
        ld_a         = 1'b0;
        ld_b         = 1'b0;
        cnt_clean_a  = 1'b0;
        cnt_clean_b  = 1'b0;
        shift_en_a   = 1'b0;
        shift_en_b   = 1'b0;
        cnt_en_a     = 1'b0;
        cnt_en_b     = 1'b0;
        ld_res       = 1'b0;
        shift_en_res = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ld_a        = 1'b1;
                ld_b        = 1'b1;
                cnt_clean_a = 1'b1;
                cnt_clean_b = 1'b1;
                state_d     = NORM;
            end
            NORM: begin
                if (!stop_a) begin
                    shift_en_a = 1'b1;
                    cnt_en_a   = 1'b1;
                end
                if (!stop_b) begin
                    shift_en_b = 1'b1;
                    cnt_en_b   = 1'b1;
                end
                if (stop_a && stop_b) begin
                    state_d = MULT;
                end
            end
            MULT: begin
                ld_res   = 1'b1;
                rs_cnt_d = RS_W'(RES_SHIFT_BASE) - RS_W'(count_a) - RS_W'(count_b);
                state_d  = SHIFT;
            end
            SHIFT: begin
                // Exit check happens on the cycle the counter reads zero.
                if (rs_cnt_q != '0) begin
                    shift_en_res = 1'b1;
                    rs_cnt_d     = rs_cnt_q - RS_W'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl with a behavioral datapath model driven by its strobes.
module tb_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        a_msb, b_msb, co_a, co_b;
    logic [2:0]  count_a, count_b;
    logic        ld_a, ld_b, cnt_clean_a, cnt_clean_b;
    logic        shift_en_a, shift_en_b, cnt_en_a, cnt_en_b;
    logic        ld_res, shift_en_res, busy, done;

    logic [15:0] op_a, op_b;
    logic [15:0] a_q, b_q;
    logic [2:0]  ca_q, cb_q;
    logic [31:0] res_q;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mult_ctrl #(.RES_SHIFT_BASE(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .a_msb        (a_msb),
        .b_msb        (b_msb),
        .co_a         (co_a),
        .co_b         (co_b),
        .count_a      (count_a),
        .count_b      (count_b),
        .ld_a         (ld_a),
        .ld_b         (ld_b),
        .cnt_clean_a  (cnt_clean_a),
        .cnt_clean_b  (cnt_clean_b),
        .shift_en_a   (shift_en_a),
        .shift_en_b   (shift_en_b),
        .cnt_en_a     (cnt_en_a),
        .cnt_en_b     (cnt_en_b),
        .ld_res       (ld_res),
        .shift_en_res (shift_en_res),
        .busy         (busy),
        .done         (done)
    );

    // Datapath model
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            ca_q  <= '0;
            cb_q  <= '0;
            res_q <= '0;
        end else begin
            if (ld_a) a_q <= op_a;
            else if (shift_en_a) a_q <= {a_q[14:0], 1'b0};
            if (ld_b) b_q <= op_b;
            else if (shift_en_b) b_q <= {b_q[14:0], 1'b0};
            if (cnt_clean_a) ca_q <= '0;
            else if (cnt_en_a) ca_q <= ca_q + 3'd1;
            if (cnt_clean_b) cb_q <= '0;
            else if (cnt_en_b) cb_q <= cb_q + 3'd1;
            if (ld_res) res_q <= {16'b0, 16'(a_q[15:8] * b_q[15:8])};
            else if (shift_en_res) res_q <= {res_q[30:0], 1'b0};
        end
    end

    assign a_msb   = a_q[15];
    assign b_msb   = b_q[15];
    assign co_a    = (ca_q == 3'd7);
    assign co_b    = (cb_q == 3'd7);
    assign count_a = ca_q;
    assign count_b = cb_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] all_outs();
        return {ld_a, ld_b, cnt_clean_a, cnt_clean_b, shift_en_a, shift_en_b,
                cnt_en_a, cnt_en_b, ld_res, shift_en_res, busy, done, 1'b0};
    endfunction

    // One operation; called at a negedge with the FSM idle.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input int e_busy, input int e_sa, input int e_sb, input int e_sres,
                          input logic [31:0] e_res, input bit hold, input bit toggle);
        int  n_busy = 0, n_sa = 0, n_sb = 0, n_sres = 0, n_ldres = 0, n_done = 0;
        int  n_async = 0, n_conf = 0;
        bit  first_busy = 1'b0, got = 1'b0;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!hold) start = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
            if (c == 0) first_busy = busy;
            if (busy) n_busy++;
            if (shift_en_a) n_sa++;
            if (shift_en_b) n_sb++;
            if (shift_en_res) n_sres++;
            if (ld_res) n_ldres++;
            if (shift_en_a != shift_en_b) n_async++;
            if ((ld_a && shift_en_a) || (ld_b && shift_en_b) || (ld_res && shift_en_res)) n_conf++;
            if (done) begin
                n_done++;
                got = 1'b1;
                break;
            end
        end
        chk({tag, " timeout"}, 32'(got), 32'd1);
        chk({tag, " first_busy"}, 32'(first_busy), 32'd1);
        chk({tag, " busy_cycles"}, 32'(n_busy), 32'(e_busy));
        chk({tag, " shifts_a"}, 32'(n_sa), 32'(e_sa));
        chk({tag, " shifts_b"}, 32'(n_sb), 32'(e_sb));
        chk({tag, " shifts_res"}, 32'(n_sres), 32'(e_sres));
        chk({tag, " ld_res"}, 32'(n_ldres), 32'd1);
        chk({tag, " conflict"}, 32'(n_conf), 32'd0);
        chk({tag, " result"}, res_q, e_res);
        if (e_sa == e_sb) chk({tag, " lockstep"}, 32'(n_async), 32'd0);
        start = hold;
        @(negedge clk);
        chk({tag, " idle_after_done"}, {31'b0, busy}, 32'd0);
        chk({tag, " done_width"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'(all_outs()), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", 32'(all_outs()), 32'd0);

        // Abort mid-NORM with an asynchronous reset.
        op_a  = 16'h0000;
        op_b  = 16'h1234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("norm_shifting", {31'b0, shift_en_a}, 32'd1);
        #2 rst = 1'b1;
        #1 chk("midop_reset", 32'(all_outs()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op("n8000_8000", 16'h8000, 16'h8000, 21, 0, 0, 16, 32'h4000_0000, 1'b0, 1'b0);
        run_op("n0100_0100", 16'h0100, 16'h0100, 14, 7, 7, 2, 32'h0001_0000, 1'b0, 1'b0);
        run_op("n0080_4000", 16'h0080, 16'h4000, 20, 7, 1, 8, 32'h0020_0000, 1'b0, 1'b0);
        run_op("n0000_1234", 16'h0000, 16'h1234, 18, 7, 3, 6, 32'h0000_0000, 1'b0, 1'b0);

        // start held high: back-to-back runs with one IDLE cycle between.
        run_op("hold1", 16'h8000, 16'h8000, 21, 0, 0, 16, 32'h4000_0000, 1'b1, 1'b0);
        run_op("hold2", 16'h0100, 16'h0100, 14, 7, 7, 2, 32'h0001_0000, 1'b1, 1'b0);
        run_op("hold3", 16'h0080, 16'h4000, 20, 7, 1, 8, 32'h0020_0000, 1'b0, 1'b0);

        run_op("toggle", 16'h0000, 16'h1234, 18, 7, 3, 6, 32'h0000_0000, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        chk("final_idle", 32'(all_outs()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
